// File: rtl/value_predict_pkg.sv
// rtl/value_predict_pkg.sv - shared entry layout and confidence constants for the load value predictor
package value_predict_pkg;

  localparam int VP_DATA_W  = 32;
  localparam int VP_ADDR_W  = 32;
  localparam int VP_INDEX_W = 8;
  localparam int VP_CONF_W  = 2;

  // Entry layout at the default geometry; the predictor keeps the same fields per index.
  typedef struct packed {
    logic                            valid;
    logic [VP_ADDR_W-VP_INDEX_W-1:0] tag;
    logic [VP_DATA_W-1:0]            last;
    logic [VP_DATA_W-1:0]            stride;
    logic [VP_CONF_W-1:0]            conf;
  } vp_entry_t;

  function automatic int conf_threshold(input int width);
    return 1 << (width - 1);
  endfunction

  function automatic int conf_sat_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/vp_conf_counter.sv
// rtl/vp_conf_counter.sv - saturating up/down confidence next-state logic
module vp_conf_counter
  import value_predict_pkg::*;
#(
  parameter int CONF_WIDTH = 2
) (
  input  logic [CONF_WIDTH-1:0] i_conf,
  input  logic                  i_up,
  output logic [CONF_WIDTH-1:0] o_conf
);

  localparam logic [CONF_WIDTH-1:0] L_CONF_MAX = CONF_WIDTH'(conf_sat_max(CONF_WIDTH));

  always_comb begin
    o_conf = i_conf;
    if (i_up) begin
      if (i_conf != L_CONF_MAX) o_conf = i_conf + CONF_WIDTH'(1);
    end else begin
      if (i_conf != '0) o_conf = i_conf - CONF_WIDTH'(1);
    end
  end

endmodule

// File: rtl/stride_value_predictor.sv
// rtl/stride_value_predictor.sv - direct-mapped stride/last-value load value predictor
module stride_value_predictor
  import value_predict_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int INDEX_WIDTH   = 8,
  parameter int CONF_WIDTH    = 2,
  parameter int STRIDE_EN     = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     lookup_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] lookup_pc_i,
  input  logic                     resolve_valid_i,
  input  logic [ADDRESS_WIDTH-1:0] resolve_pc_i,
  input  logic [DATA_WIDTH-1:0]    resolve_data_i,
  input  logic                     resolve_predicted_i,
  input  logic [DATA_WIDTH-1:0]    resolve_pred_data_i,
  input  logic                     flush_i,
  output logic                     predict_valid_o,
  output logic [DATA_WIDTH-1:0]    predict_data_o,
  output logic                     mispredict_o,
  output logic [31:0]              stat_predictions_o,
  output logic [31:0]              stat_mispredicts_o
);

  localparam int TAG_W = ADDRESS_WIDTH - INDEX_WIDTH;
  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam logic [CONF_WIDTH-1:0] L_CONF_THR = CONF_WIDTH'(conf_threshold(CONF_WIDTH));

  logic [DEPTH-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag    [DEPTH];
  logic [DATA_WIDTH-1:0] r_last   [DEPTH];
  logic [DATA_WIDTH-1:0] r_stride [DEPTH];
  logic [CONF_WIDTH-1:0] r_conf   [DEPTH];

  logic                  r_predict_valid;
  logic [DATA_WIDTH-1:0] r_predict_data;
  logic                  r_mispredict;
  logic [31:0]           r_stat_pred;
  logic [31:0]           r_stat_mis;

  logic [INDEX_WIDTH-1:0] w_lk_idx;
  logic [TAG_W-1:0]       w_lk_tag;
  logic                   w_lk_hit;
  logic [DATA_WIDTH-1:0]  w_lk_pred;
  logic [INDEX_WIDTH-1:0] w_rs_idx;
  logic [TAG_W-1:0]       w_rs_tag;
  logic                   w_rs_hit;
  logic                   w_rs_update;
  logic                   w_rs_correct;
  logic [DATA_WIDTH-1:0]  w_rs_pred;
  logic [DATA_WIDTH-1:0]  w_rs_stride;
  logic [CONF_WIDTH-1:0]  w_rs_conf;
  logic                   w_mispredict;

  assign w_lk_idx  = lookup_pc_i[INDEX_WIDTH-1:0];
  assign w_lk_tag  = lookup_pc_i[ADDRESS_WIDTH-1:INDEX_WIDTH];
  assign w_lk_pred = r_last[w_lk_idx] + r_stride[w_lk_idx];
  // Lookups read pre-update table contents; a same-cycle flush suppresses the prediction.
  assign w_lk_hit  = lookup_valid_i && !flush_i && r_valid[w_lk_idx] &&
                     (r_tag[w_lk_idx] == w_lk_tag) && (r_conf[w_lk_idx] >= L_CONF_THR);

  assign w_rs_idx     = resolve_pc_i[INDEX_WIDTH-1:0];
  assign w_rs_tag     = resolve_pc_i[ADDRESS_WIDTH-1:INDEX_WIDTH];
  assign w_rs_hit     = r_valid[w_rs_idx] && (r_tag[w_rs_idx] == w_rs_tag);
  assign w_rs_update  = resolve_valid_i && !flush_i;
  assign w_rs_pred    = r_last[w_rs_idx] + r_stride[w_rs_idx];
  assign w_rs_correct = (resolve_data_i == w_rs_pred);
  assign w_rs_stride  = (STRIDE_EN != 0) ? (resolve_data_i - r_last[w_rs_idx]) : '0;
  assign w_mispredict = resolve_valid_i && resolve_predicted_i &&
                        (resolve_data_i != resolve_pred_data_i);

  vp_conf_counter #(
    .CONF_WIDTH(CONF_WIDTH)
  ) u_conf (
    .i_conf(r_conf[w_rs_idx]),
    .i_up  (w_rs_correct),
    .o_conf(w_rs_conf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid         <= '0;
      r_predict_valid <= 1'b0;
      r_predict_data  <= '0;
      r_mispredict    <= 1'b0;
      r_stat_pred     <= '0;
      r_stat_mis      <= '0;
    end else begin
      r_predict_valid <= w_lk_hit;
      if (w_lk_hit) r_predict_data <= w_lk_pred;
      r_mispredict <= w_mispredict;
      if (r_predict_valid && (r_stat_pred != '1)) r_stat_pred <= r_stat_pred + 32'd1;
      if (r_mispredict && (r_stat_mis != '1)) r_stat_mis <= r_stat_mis + 32'd1;
      if (flush_i) begin
        r_valid <= '0;
      end else if (resolve_valid_i) begin
        r_valid[w_rs_idx] <= 1'b1;
      end
    end
  end

  // Payload storage is unreset; a cleared valid bit makes any stale write harmless.
  always_ff @(posedge clk_i) begin
    if (w_rs_update) begin
      r_tag[w_rs_idx]    <= w_rs_tag;
      r_last[w_rs_idx]   <= resolve_data_i;
      r_stride[w_rs_idx] <= w_rs_hit ? w_rs_stride : '0;
      r_conf[w_rs_idx]   <= w_rs_hit ? w_rs_conf : '0;
    end
  end

  assign predict_valid_o    = r_predict_valid;
  assign predict_data_o     = r_predict_data;
  assign mispredict_o       = r_mispredict;
  assign stat_predictions_o = r_stat_pred;
  assign stat_mispredicts_o = r_stat_mis;

endmodule

// File: tb/tb_stride_value_predictor.sv
// tb/tb_stride_value_predictor.sv - randomized model-checked bench for the load value predictor
module tb_stride_value_predictor;
  import value_predict_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        resolve_valid_i;
  logic [31:0] resolve_pc_i;
  logic [31:0] resolve_data_i;
  logic        resolve_predicted_i;
  logic [31:0] resolve_pred_data_i;
  logic        flush_i;

  logic        pv_l, pv_s, mp_l, mp_s;
  logic [31:0] pd_l, pd_s, sp_l, sp_s, sm_l, sm_s;

  int checks = 0;
  int errors = 0;

  vp_entry_t   tbl [2][256];
  logic        e_pv [2];
  logic [31:0] e_pd [2];
  logic [31:0] e_sp [2];
  logic [31:0] e_sm [2];
  logic        e_mp;

  logic [31:0] gval [8];
  logic [31:0] gstride [8];

  always #5 clk_i = ~clk_i;

  stride_value_predictor #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .INDEX_WIDTH(8), .CONF_WIDTH(2), .STRIDE_EN(0)
  ) u_dut_l (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_data_i(resolve_data_i), .resolve_predicted_i(resolve_predicted_i),
    .resolve_pred_data_i(resolve_pred_data_i), .flush_i(flush_i),
    .predict_valid_o(pv_l), .predict_data_o(pd_l), .mispredict_o(mp_l),
    .stat_predictions_o(sp_l), .stat_mispredicts_o(sm_l)
  );

  stride_value_predictor #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .INDEX_WIDTH(8), .CONF_WIDTH(2), .STRIDE_EN(1)
  ) u_dut_s (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_data_i(resolve_data_i), .resolve_predicted_i(resolve_predicted_i),
    .resolve_pred_data_i(resolve_pred_data_i), .flush_i(flush_i),
    .predict_valid_o(pv_s), .predict_data_o(pd_s), .mispredict_o(mp_s),
    .stat_predictions_o(sp_s), .stat_mispredicts_o(sm_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pv_l", {63'd0, pv_l}, {63'd0, e_pv[0]});
    chk("pv_s", {63'd0, pv_s}, {63'd0, e_pv[1]});
    chk("pd_l", {32'd0, pd_l}, {32'd0, e_pd[0]});
    chk("pd_s", {32'd0, pd_s}, {32'd0, e_pd[1]});
    chk("mp_l", {63'd0, mp_l}, {63'd0, e_mp});
    chk("mp_s", {63'd0, mp_s}, {63'd0, e_mp});
    chk("sp_l", {32'd0, sp_l}, {32'd0, e_sp[0]});
    chk("sp_s", {32'd0, sp_s}, {32'd0, e_sp[1]});
    chk("sm_l", {32'd0, sm_l}, {32'd0, e_sm[0]});
    chk("sm_s", {32'd0, sm_s}, {32'd0, e_sm[1]});
  endtask

  // Advance the model by one clock using the currently driven inputs, then check the DUTs.
  task automatic step();
    logic [7:0]  li, ri;
    logic [23:0] lt, rt;
    logic [31:0] pr;
    int c;
    for (int m = 0; m < 2; m++) begin
      if (e_pv[m] && e_sp[m] != 32'hFFFF_FFFF) e_sp[m] = e_sp[m] + 32'd1;
      if (e_mp && e_sm[m] != 32'hFFFF_FFFF) e_sm[m] = e_sm[m] + 32'd1;
    end
    li = lookup_pc_i[7:0];
    lt = lookup_pc_i[31:8];
    ri = resolve_pc_i[7:0];
    rt = resolve_pc_i[31:8];
    for (int m = 0; m < 2; m++) begin
      e_pv[m] = lookup_valid_i && !flush_i && tbl[m][li].valid &&
                (tbl[m][li].tag == lt) && (int'(tbl[m][li].conf) >= 2);
      if (e_pv[m]) e_pd[m] = tbl[m][li].last + tbl[m][li].stride;
      if (resolve_valid_i && !flush_i) begin
        if (tbl[m][ri].valid && tbl[m][ri].tag == rt) begin
          pr = tbl[m][ri].last + tbl[m][ri].stride;
          c = int'(tbl[m][ri].conf);
          if (resolve_data_i == pr) c = (c == 3) ? 3 : c + 1;
          else c = (c == 0) ? 0 : c - 1;
          tbl[m][ri].conf   = 2'(c);
          tbl[m][ri].stride = (m == 1) ? resolve_data_i - tbl[m][ri].last : 32'd0;
          tbl[m][ri].last   = resolve_data_i;
        end else begin
          tbl[m][ri].valid  = 1'b1;
          tbl[m][ri].tag    = rt;
          tbl[m][ri].last   = resolve_data_i;
          tbl[m][ri].stride = 32'd0;
          tbl[m][ri].conf   = 2'd0;
        end
      end
      if (flush_i) for (int k = 0; k < 256; k++) tbl[m][k].valid = 1'b0;
    end
    e_mp = resolve_valid_i && resolve_predicted_i && (resolve_data_i != resolve_pred_data_i);
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic lv, input logic [31:0] lpc, input logic rv,
                       input logic [31:0] rpc, input logic [31:0] rd, input logic rp,
                       input logic [31:0] rpd, input logic fl);
    lookup_valid_i      = lv;
    lookup_pc_i         = lpc;
    resolve_valid_i     = rv;
    resolve_pc_i        = rpc;
    resolve_data_i      = rd;
    resolve_predicted_i = rp;
    resolve_pred_data_i = rpd;
    flush_i             = fl;
    step();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 256; k++) tbl[m][k].valid = 1'b0;
      e_pv[m] = 1'b0;
      e_pd[m] = 32'd0;
      e_sp[m] = 32'd0;
      e_sm[m] = 32'd0;
    end
    e_mp = 1'b0;
    compare_all();
    @(posedge clk_i);
    #1;
    compare_all();
    rst_ni = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = 32'h10 + 32'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) pc = pc + 32'h100;
    return pc;
  endfunction

  initial begin
    int k;
    logic [31:0] pc, d;
    logic [31:0] steps [4];
    steps[0] = 32'd0; steps[1] = 32'd1; steps[2] = 32'd4; steps[3] = 32'hFFFF_FFFD;
    rst_ni = 1'b1;
    lookup_valid_i = 0; lookup_pc_i = 0; resolve_valid_i = 0; resolve_pc_i = 0;
    resolve_data_i = 0; resolve_predicted_i = 0; resolve_pred_data_i = 0; flush_i = 0;
    #1;
    do_reset();

    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("r034_pv_l", {63'd0, pv_l}, 64'd0);
    chk("r034_pv_s", {63'd0, pv_s}, 64'd0);
    chk("r034_sp_s", {32'd0, sp_s}, 64'd0);
    chk("r034_sm_s", {32'd0, sm_s}, 64'd0);

    repeat (3) drive(0, 0, 1, 32'h40, 32'd5, 0, 0, 0);
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("r035_pv_l", {63'd0, pv_l}, 64'd1);
    chk("r035_pd_l", {32'd0, pd_l}, 64'd5);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r035_sp_l", {32'd0, sp_l}, 64'd1);

    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'h44, 32'(10 + 4 * i), 0, 0, 0);
    drive(1, 32'h44, 0, 0, 0, 0, 0, 0);
    chk("r036_pv_s", {63'd0, pv_s}, 64'd1);
    chk("r036_pd_s", {32'd0, pd_s}, 64'd26);
    chk("r036_pv_l", {63'd0, pv_l}, 64'd0);

    repeat (3) drive(0, 0, 1, 32'h004, 32'd3, 0, 0, 0);
    drive(1, 32'h004, 0, 0, 0, 0, 0, 0);
    chk("r037_trained", {63'd0, pv_s}, 64'd1);
    drive(0, 0, 1, 32'h104, 32'd3, 0, 0, 0);
    drive(1, 32'h004, 0, 0, 0, 0, 0, 0);
    chk("r037_alias_pv", {63'd0, pv_s}, 64'd0);

    drive(0, 0, 1, 32'h80, 32'd9, 1, 32'd7, 0);
    chk("r038_mp", {63'd0, mp_s}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r038_mp_off", {63'd0, mp_s}, 64'd0);
    chk("r038_sm", {32'd0, sm_s}, 64'd1);
    drive(0, 0, 1, 32'h80, 32'd9, 1, 32'd9, 0);
    chk("r038_nopulse", {63'd0, mp_l}, 64'd0);

    drive(1, 32'h40, 1, 32'h40, 32'd5, 0, 0, 1);
    chk("r039_flush_pv", {63'd0, pv_l}, 64'd0);
    drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("r039_after_flush", {63'd0, pv_l}, 64'd0);

    repeat (3) drive(0, 0, 1, 32'h48, 32'd1, 0, 0, 0);
    drive(1, 32'h48, 1, 32'h80, 32'd4, 1, 32'd5, 0);
    chk("r039_pre_rst_pv", {63'd0, pv_s}, 64'd1);
    chk("r039_pre_rst_mp", {63'd0, mp_s}, 64'd1);
    resolve_valid_i = 1; resolve_pc_i = 32'h48; resolve_data_i = 32'd1;
    do_reset();
    drive(1, 32'h48, 0, 0, 0, 0, 0, 0);
    chk("r031_discard", {63'd0, pv_s}, 64'd0);
    repeat (3) drive(0, 0, 1, 32'h48, 32'd1, 0, 0, 0);
    drive(1, 32'h48, 0, 0, 0, 0, 0, 0);
    chk("r031_accept", {63'd0, pv_s}, 64'd1);

    for (int i = 0; i < 8; i++) begin
      gval[i] = $urandom();
      gstride[i] = steps[$urandom_range(0, 3)];
    end
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      pc = rand_pc();
      k = int'(pc[3:0]) + (pc[8] ? 4 : 0);
      if ($urandom_range(0, 4) != 0) gval[k] = gval[k] + gstride[k];
      else gval[k] = $urandom_range(0, 15);
      d = gval[k];
      drive($urandom_range(0, 9) < 7, rand_pc(),
            $urandom_range(0, 9) < 6, pc, d,
            $urandom_range(0, 9) < 3, ($urandom_range(0, 1) == 1) ? d : d ^ 32'h1,
            $urandom_range(0, 63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
